// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// cdb_arbiter : merges ALU/LSB results onto a registered CDB, with per-source
//               FIFOs. Optional CDB_PERF_EN adds grant/conflict counters.
// Revision    : 1.0
// ============================================================================
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module cdb_arbiter #(
  parameter int ROB_W = `ROB_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_value,
  output logic             alu_stall,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_value,
  output logic             lsb_stall,
`ifdef CDB_PERF_EN
  output logic [31:0]      perf_alu_grants,
  output logic [31:0]      perf_lsb_grants,
  output logic [31:0]      perf_conflicts,
`endif
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [31:0]      cdb_value
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DW    = ROB_W + 32;
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - 2);

  // Index 0 is the ALU source, index 1 the LSB source.
  logic [1:0]              in_vld;
  logic [1:0][DW-1:0]      in_data;
  logic [1:0][DW-1:0]      head;
  logic [1:0][DW-1:0]      cand_data;
  logic [1:0][CNT_W-1:0]   cnt;
  logic [1:0]              nonempty;
  logic [1:0]              cand;
  logic [1:0]              grant;
  logic [1:0]              pop;
  logic [1:0]              push;
  logic                    prio_q, prio_d;
  logic [DW-1:0]           win_data;
  logic                    cdb_valid_q;
  logic [DW-1:0]           cdb_data_q;

  assign in_vld     = {lsb_valid, alu_valid};
  assign in_data[0] = {alu_rob_id, alu_value};
  assign in_data[1] = {lsb_rob_id, lsb_value};

  always_comb begin
    cand      = 2'b00;
    cand_data = '0;
    grant     = 2'b00;
    prio_d    = prio_q;
    pop       = 2'b00;
    push      = 2'b00;
    for (int s = 0; s < 2; s++) begin
      cand[s]      = nonempty[s] | in_vld[s];
      cand_data[s] = nonempty[s] ? head[s] : in_data[s];
    end
    if (cand == 2'b11) begin
      grant  = prio_q ? 2'b10 : 2'b01;
      prio_d = ~prio_q;
    end else begin
      grant  = cand;
    end
    // A granted source with an empty FIFO is served by write-through, so no push.
    for (int s = 0; s < 2; s++) begin
      pop[s]  = grant[s] & nonempty[s];
      push[s] = in_vld[s] & ~(grant[s] & ~nonempty[s]);
    end
    win_data = grant[1] ? cand_data[1] : cand_data[0];
  end

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;

    always_comb begin
      do_push = push[s] & ((cnt_q != FULL_LVL) | pop[s]);
      cnt_d   = cnt_q;
      if (do_push && !pop[s]) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!do_push && pop[s]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else if (rdy_in) begin
        if (clear) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          if (do_push) wr_q <= wr_q + 1'b1;
          if (pop[s])  rd_q <= rd_q + 1'b1;
          cnt_q <= cnt_d;
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && !clear && do_push) begin
        mem_q[wr_q] <= in_data[s];
      end
    end

    a_no_overflow : assert property (@(posedge clk_in) disable iff (rst_in)
      (rdy_in && !clear) |-> !(push[s] && !pop[s] && cnt_q == FULL_LVL))
      else $error("cdb_arbiter: push to full FIFO %0d dropped", s);

    assign cnt[s]      = cnt_q;
    assign nonempty[s] = (cnt_q != '0);
    assign head[s]     = mem_q[rd_q];
  end

  assign alu_stall = (cnt[0] >= STALL_LVL);
  assign lsb_stall = (cnt[1] >= STALL_LVL);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      prio_q      <= 1'b0;
    end else if (rdy_in) begin
      if (clear) begin
        cdb_valid_q <= 1'b0;
        prio_q      <= 1'b0;
      end else begin
        cdb_valid_q <= |grant;
        if (|grant) cdb_data_q <= win_data;
        prio_q <= prio_d;
      end
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_data_q[DW-1:32];
  assign cdb_value  = cdb_data_q[31:0];

`ifdef CDB_PERF_EN
  logic [31:0] perf_alu_q, perf_lsb_q, perf_conf_q;

  // Counters survive a pipeline flush; only reset clears them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_alu_q  <= '0;
      perf_lsb_q  <= '0;
      perf_conf_q <= '0;
    end else if (rdy_in && !clear) begin
      if (grant[0])      perf_alu_q  <= perf_alu_q + 1'b1;
      if (grant[1])      perf_lsb_q  <= perf_lsb_q + 1'b1;
      if (cand == 2'b11) perf_conf_q <= perf_conf_q + 1'b1;
    end
  end

  assign perf_alu_grants = perf_alu_q;
  assign perf_lsb_grants = perf_lsb_q;
  assign perf_conflicts  = perf_conf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cdb_arbiter : scoreboard bench for cdb_arbiter (ROB_W=4, DEPTH=4).
// Revision       : 1.0
// ============================================================================
module tb_cdb_arbiter;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] val;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear  = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_rob_id = '0;
  logic [31:0] alu_value = '0;
  logic        alu_stall;
  logic        lsb_valid = 1'b0;
  logic [3:0]  lsb_rob_id = '0;
  logic [31:0] lsb_value = '0;
  logic        lsb_stall;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
`ifdef CDB_PERF_EN
  logic [31:0] perf_alu_grants, perf_lsb_grants, perf_conflicts;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t e;
  exp_t last;

  cdb_arbiter #(.ROB_W(4), .DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_stall(alu_stall),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_stall(lsb_stall),
`ifdef CDB_PERF_EN
    .perf_alu_grants(perf_alu_grants), .perf_lsb_grants(perf_lsb_grants),
    .perf_conflicts(perf_conflicts),
`endif
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [3:0] t, input logic [31:0] v, input bit track);
    alu_valid = 1'b1; alu_rob_id = t; alu_value = v;
    if (track) sb.push_back('{tag: t, val: v});
  endtask

  task automatic drive_lsb(input logic [3:0] t, input logic [31:0] v, input bit track);
    lsb_valid = 1'b1; lsb_rob_id = t; lsb_value = v;
    if (track) sb.push_back('{tag: t, val: v});
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    clear  = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    clear  = 1'b0;
    n_tests++;
    if (cdb_valid !== 1'b0 || cdb_rob_id !== 4'd0 || cdb_value !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cdb: got v=%b tag=%0d val=%h, want 0/0/0", cdb_valid, cdb_rob_id, cdb_value);
    end
    n_tests++;
    if (alu_stall !== 1'b0 || lsb_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got alu=%b lsb=%b, want 0/0", alu_stall, lsb_stall);
    end
  endtask

  task automatic test_single;
    drive_alu(4'd3, 32'h11, 1'b1);
    tick();
    idle_inputs();
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL single_out: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (cdb_valid !== 1'b1 || cdb_rob_id !== e.tag || cdb_value !== e.val) begin
        n_fail++;
        $display("FAIL single_out: got v=%b tag=%0d val=%h, want v=1 tag=%0d val=%h",
                 cdb_valid, cdb_rob_id, cdb_value, e.tag, e.val);
      end
    end
    tick();
    n_tests++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got v=%b, want 0", cdb_valid);
    end
  endtask

  task automatic test_conflict;
    drive_alu(4'd1, 32'h100, 1'b1);
    drive_lsb(4'd2, 32'h200, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      idle_inputs();
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL conflict_out%0d: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if (cdb_valid !== 1'b1 || cdb_rob_id !== e.tag || cdb_value !== e.val) begin
          n_fail++;
          $display("FAIL conflict_out%0d: got v=%b tag=%0d val=%h, want v=1 tag=%0d val=%h",
                   k, cdb_valid, cdb_rob_id, cdb_value, e.tag, e.val);
        end
      end
    end
    tick();
    n_tests++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL conflict_idle: got v=%b, want 0", cdb_valid);
    end
  endtask

  task automatic test_back_to_back;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      drive_alu(4'(i), 32'hA000_0000 + i, 1'b1);
      drive_lsb(4'(8 + i), 32'hB000_0000 + i, 1'b1);
      tick();
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_out: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if (cdb_valid !== 1'b1 || cdb_rob_id !== e.tag || cdb_value !== e.val) begin
          n_fail++;
          $display("FAIL b2b_out%0d: got v=%b tag=%0d val=%h, want v=1 tag=%0d val=%h",
                   i, cdb_valid, cdb_rob_id, cdb_value, e.tag, e.val);
        end
      end
      if (i == 0 || i == 2 || i == 3) begin
        n_tests++;
        if (alu_stall !== (i == 3) || lsb_stall !== (i >= 2)) begin
          n_fail++;
          $display("FAIL b2b_stall%0d: got alu=%b lsb=%b, want alu=%b lsb=%b",
                   i, alu_stall, lsb_stall, (i == 3), (i >= 2));
        end
      end
    end
    idle_inputs();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      tick();
      n_tests++;
      e = sb.pop_front();
      if (cdb_valid !== 1'b1 || cdb_rob_id !== e.tag || cdb_value !== e.val) begin
        n_fail++;
        $display("FAIL b2b_drain: got v=%b tag=%0d val=%h, want v=1 tag=%0d val=%h",
                 cdb_valid, cdb_rob_id, cdb_value, e.tag, e.val);
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_timeout: %0d entries left, want 0", sb.size());
      sb.delete();
    end
    tick();
    n_tests++;
    if (cdb_valid !== 1'b0 || alu_stall !== 1'b0 || lsb_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got v=%b alu=%b lsb=%b, want 0/0/0", cdb_valid, alu_stall, lsb_stall);
    end
  endtask

  task automatic test_clear;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      drive_alu(4'(i), 32'hC000_0000 + i, 1'b1);
      drive_lsb(4'(8 + i), 32'hD000_0000 + i, 1'b1);
      tick();
      n_tests++;
      e = sb.pop_front();
      if (cdb_valid !== 1'b1 || cdb_rob_id !== e.tag || cdb_value !== e.val) begin
        n_fail++;
        $display("FAIL clear_fill%0d: got v=%b tag=%0d val=%h, want v=1 tag=%0d val=%h",
                 i, cdb_valid, cdb_rob_id, cdb_value, e.tag, e.val);
      end
    end
    drive_alu(4'd7, 32'hDEAD, 1'b0);
    drive_lsb(4'd15, 32'hBEEF, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle_inputs();
    sb.delete();
    n_tests++;
    if (cdb_valid !== 1'b0 || alu_stall !== 1'b0 || lsb_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_now: got v=%b alu=%b lsb=%b, want 0/0/0", cdb_valid, alu_stall, lsb_stall);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL clear_empty%0d: got v=%b, want 0", k, cdb_valid);
      end
    end
  endtask

  task automatic test_freeze;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      drive_alu(4'(i), 32'hE000_0000 + i, 1'b1);
      drive_lsb(4'(8 + i), 32'hF000_0000 + i, 1'b1);
      tick();
      n_tests++;
      e = sb.pop_front();
      last = e;
      if (cdb_valid !== 1'b1 || cdb_rob_id !== e.tag || cdb_value !== e.val) begin
        n_fail++;
        $display("FAIL freeze_fill%0d: got v=%b tag=%0d val=%h, want v=1 tag=%0d val=%h",
                 i, cdb_valid, cdb_rob_id, cdb_value, e.tag, e.val);
      end
    end
    rdy_in = 1'b0;
    drive_alu(4'd7, 32'h5555, 1'b0);
    drive_lsb(4'd15, 32'h6666, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_id !== last.tag || cdb_value !== last.val ||
          alu_stall !== 1'b1 || lsb_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_hold%0d: got v=%b tag=%0d val=%h stl=%b%b, want v=1 tag=%0d val=%h stl=11",
                 k, cdb_valid, cdb_rob_id, cdb_value, alu_stall, lsb_stall, last.tag, last.val);
      end
    end
    rdy_in = 1'b1;
    idle_inputs();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      tick();
      n_tests++;
      e = sb.pop_front();
      if (cdb_valid !== 1'b1 || cdb_rob_id !== e.tag || cdb_value !== e.val) begin
        n_fail++;
        $display("FAIL freeze_resume%0d: got v=%b tag=%0d val=%h, want v=1 tag=%0d val=%h",
                 k, cdb_valid, cdb_rob_id, cdb_value, e.tag, e.val);
      end
    end
    tick();
    n_tests++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL freeze_end: got v=%b, want 0", cdb_valid);
    end
  endtask

`ifdef CDB_PERF_EN
  task automatic test_perf;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    drive_alu(4'd1, 32'h100, 1'b0);
    drive_lsb(4'd2, 32'h200, 1'b0);
    tick();
    idle_inputs();
    tick();
    tick();
    n_tests++;
    if (perf_alu_grants !== 32'd1 || perf_lsb_grants !== 32'd1 || perf_conflicts !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_counts: got alu=%0d lsb=%0d conf=%0d, want 1/1/1",
               perf_alu_grants, perf_lsb_grants, perf_conflicts);
    end
    do_clear();
    n_tests++;
    if (perf_alu_grants !== 32'd1 || perf_conflicts !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_clear: got alu=%0d conf=%0d, want 1/1", perf_alu_grants, perf_conflicts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_back_to_back();
    test_clear();
    test_freeze();
`ifdef CDB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
